// File: rtl/router_chan_ctrl.sv
// router_chan_ctrl: latches the destination channel, steers write enable and
// full status, publishes per-port valid, and soft-resets an output FIFO whose
// data sits unread for TIMEOUT consecutive cycles.
// Optional feature macro: ROUTER_CHAN_STATS_EN adds drop_cnt, one 8-bit
// saturating soft-reset counter per channel.
module router_chan_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        detect_add,
  input  logic [1:0]  data_in,
  input  logic        write_enb_reg,
  input  logic [2:0]  read_enb,
  input  logic [2:0]  empty,
  input  logic [2:0]  full,
  output logic [2:0]  write_enb,
  output logic        fifo_full,
  output logic [2:0]  vld_out,
  output logic [2:0]  soft_reset
`ifdef ROUTER_CHAN_STATS_EN
  ,
  output logic [23:0] drop_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       addr_reg;
  logic [CNT_W-1:0] cnt [3];

  // Destination latch: captured on every address-decode cycle, 2'b11 = none.
  always_ff @(posedge clk) begin
    if (!resetn)         addr_reg <= 2'b11;
    else if (detect_add) addr_reg <= data_in;
  end

  // Steer the FSM write request and the selected FIFO's full flag.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    case (addr_reg)
      2'b00: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full[0];
      end
      2'b01: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full[1];
      end
      2'b10: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full[2];
      end
      default: begin
        write_enb = '0;
        fifo_full = 1'b0;
      end
    endcase
  end

  // Port valid is simply the inverted FIFO empty flag.
  always_comb begin
    vld_out = ~empty;
  end

  // Per-channel unread timers; a pulse fires on the edge completing TIMEOUT
  // valid-and-unread cycles, and the timer restarts from zero afterwards.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
      soft_reset <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (!vld_out[i] || read_enb[i]) begin
          cnt[i]        <= '0;
          soft_reset[i] <= 1'b0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]        <= '0;
          soft_reset[i] <= 1'b1;
        end else begin
          cnt[i]        <= cnt[i] + CNT_W'(1);
          soft_reset[i] <= 1'b0;
        end
      end
    end
  end

`ifdef ROUTER_CHAN_STATS_EN
  // Count soft-reset pulses per channel, saturating at 255.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (soft_reset[i] && (drop_cnt[8*i +: 8] != 8'hFF))
          drop_cnt[8*i +: 8] <= drop_cnt[8*i +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_router_chan_ctrl.sv
// Testbench for router_chan_ctrl: vector table, directed timeout sequences and
// randomized traffic against a run-length reference model.
module tb_router_chan_ctrl;

  localparam int T = 30;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        detect_add = 1'b0;
  logic [1:0]  data_in = 2'b00;
  logic        write_enb_reg = 1'b0;
  logic [2:0]  read_enb = 3'b000;
  logic [2:0]  empty = 3'b111;
  logic [2:0]  full = 3'b000;
  logic [2:0]  write_enb;
  logic        fifo_full;
  logic [2:0]  vld_out;
  logic [2:0]  soft_reset;
`ifdef ROUTER_CHAN_STATS_EN
  logic [23:0] drop_cnt;
`endif

  router_chan_ctrl #(.TIMEOUT(T), .CNT_W(5)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb      (read_enb),
    .empty         (empty),
    .full          (full),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out       (vld_out),
    .soft_reset    (soft_reset)
`ifdef ROUTER_CHAN_STATS_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: destination, run length of valid-unread cycles, pulses.
  bit m_valid = 1'b0;
  int m_addr  = 3;
  int m_run [3];
  bit m_sr  [3];
  int m_drop[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, step the model
  // at posedge, then check registered outputs.
  task automatic cyc(input logic rn, input logic da, input logic [1:0] din,
                     input logic wer, input logic [2:0] rd,
                     input logic [2:0] emp, input logic [2:0] fl);
    logic [2:0] exp_we;
    logic       exp_ff;
    @(negedge clk);
    resetn = rn; detect_add = da; data_in = din; write_enb_reg = wer;
    read_enb = rd; empty = emp; full = fl;
    #1;
    if (m_valid) begin
      exp_we = (wer && m_addr != 3) ? 3'(1 << m_addr) : 3'b000;
      exp_ff = (m_addr != 3) ? fl[m_addr] : 1'b0;
      chk("write_enb", {29'd0, write_enb}, {29'd0, exp_we});
      chk("fifo_full", {31'd0, fifo_full}, {31'd0, exp_ff});
    end
    chk("vld_out", {29'd0, vld_out}, {29'd0, ~emp});
    @(posedge clk);
    if (!rn) begin
      m_valid = 1'b1;
      m_addr  = 3;
      for (int i = 0; i < 3; i++) begin
        m_run[i] = 0; m_sr[i] = 1'b0; m_drop[i] = 0;
      end
    end else begin
      if (da) m_addr = int'(din);
      for (int i = 0; i < 3; i++) begin
        if (m_sr[i] && m_drop[i] < 255) m_drop[i]++;
        if (emp[i] || rd[i]) begin
          m_run[i] = 0; m_sr[i] = 1'b0;
        end else begin
          m_run[i]++;
          if (m_run[i] == T) begin
            m_sr[i] = 1'b1; m_run[i] = 0;
          end else begin
            m_sr[i] = 1'b0;
          end
        end
      end
    end
    #1;
    if (m_valid) begin
      chk("soft_reset", {29'd0, soft_reset}, {29'd0, m_sr[2], m_sr[1], m_sr[0]});
`ifdef ROUTER_CHAN_STATS_EN
      chk("drop_cnt", {8'd0, drop_cnt},
          {8'd0, 8'(m_drop[2]), 8'(m_drop[1]), 8'(m_drop[0])});
`endif
    end
  endtask

  typedef struct {
    logic       rn, da;
    logic [1:0] din;
    logic       wer;
    logic [2:0] rd, emp, fl;
    logic       chk_en;
    logic [2:0] x_we;
    logic       x_ff;
    logic [2:0] x_vld;
  } vec_t;

  vec_t vt [10];

  initial begin
    // Expected outputs apply during the row, before its clock edge.
    vt[0] = '{1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
    vt[1] = '{1'b1, 1'b1, 2'b01, 1'b0, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 3'b000};
    vt[2] = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 3'b111, 3'b010, 1'b1, 3'b010, 1'b1, 3'b000};
    vt[3] = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 3'b111, 3'b001, 1'b1, 3'b010, 1'b0, 3'b000};
    vt[4] = '{1'b1, 1'b1, 2'b11, 1'b1, 3'b000, 3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 3'b000};
    vt[5] = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 3'b111, 3'b111, 1'b1, 3'b000, 1'b0, 3'b000};
    vt[6] = '{1'b1, 1'b1, 2'b10, 1'b0, 3'b000, 3'b011, 3'b100, 1'b1, 3'b000, 1'b0, 3'b100};
    vt[7] = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 3'b101, 3'b100, 1'b1, 3'b100, 1'b1, 3'b010};
    vt[8] = '{1'b1, 1'b1, 2'b00, 1'b1, 3'b000, 3'b110, 3'b001, 1'b1, 3'b100, 1'b0, 3'b001};
    vt[9] = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 3'b111, 3'b001, 1'b1, 3'b001, 1'b1, 3'b000};

    for (int r = 0; r < 10; r++) begin
      fork
        cyc(vt[r].rn, vt[r].da, vt[r].din, vt[r].wer, vt[r].rd, vt[r].emp, vt[r].fl);
        begin
          @(negedge clk); #1;
          if (vt[r].chk_en) begin
            chk("tbl_write_enb", {29'd0, write_enb}, {29'd0, vt[r].x_we});
            chk("tbl_fifo_full", {31'd0, fifo_full}, {31'd0, vt[r].x_ff});
            chk("tbl_vld_out", {29'd0, vld_out}, {29'd0, vt[r].x_vld});
          end
        end
      join
    end

    // Held unread on port 2: pulses at edges 30 and 60, one cycle each.
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b111, 3'b000);
    for (int k = 1; k <= 62; k++) begin
      cyc(1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 3'b011, 3'b000);
      chk("hold_sr2", {31'd0, soft_reset[2]}, {31'd0, 1'((k == 30) || (k == 60))});
    end

    // Read on the would-be firing edge suppresses the pulse and restarts.
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b111, 3'b000);
    for (int k = 1; k <= 62; k++) begin
      cyc(1'b1, 1'b0, 2'b00, 1'b0, (k == 30) ? 3'b100 : 3'b000, 3'b011, 3'b000);
      chk("rdwin_sr2", {31'd0, soft_reset[2]}, {31'd0, 1'(k == 60)});
    end

    // All ports valid, port 0 read at cycle 10: ports 1,2 fire at 30, port 0 at 40.
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b111, 3'b000);
    for (int k = 1; k <= 42; k++) begin
      cyc(1'b1, 1'b0, 2'b00, 1'b0, (k == 10) ? 3'b001 : 3'b000, 3'b000, 3'b000);
      chk("indep_sr", {29'd0, soft_reset}, {29'd0, 1'(k == 30), 1'(k == 30), 1'(k == 40)});
    end

    // Mid-packet reset with cnt_0=20 and addr=10.
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b111, 3'b000);
    cyc(1'b1, 1'b1, 2'b10, 1'b0, 3'b000, 3'b110, 3'b000);
    for (int k = 2; k <= 20; k++) cyc(1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 3'b110, 3'b000);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 3'b000, 3'b110, 3'b111);
    chk("rst_sr", {29'd0, soft_reset}, 32'd0);
    chk("rst_we", {29'd0, write_enb}, 32'd0);
    chk("rst_ff", {31'd0, fifo_full}, 32'd0);
    for (int k = 1; k <= 31; k++) begin
      cyc(1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 3'b110, 3'b111);
      chk("rst_cnt_sr0", {31'd0, soft_reset[0]}, {31'd0, 1'(k == 30)});
    end

`ifdef ROUTER_CHAN_STATS_EN
    // 300 forced timeouts on channel 0 saturate its drop counter.
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b111, 3'b000);
    for (int k = 1; k <= 300 * T + 2; k++)
      cyc(1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 3'b110, 3'b000);
    chk("drop_sat", {24'd0, drop_cnt[7:0]}, 32'd255);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [2:0] emp, rd;
      for (int b = 0; b < 3; b++) begin
        emp[b] = ($urandom_range(0, 9) == 0);
        rd[b]  = ($urandom_range(0, 49) == 0);
      end
      cyc(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 3) == 0),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd, emp,
          3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_chan_ctrl.md
Name: router_chan_ctrl

Overview:
- Channel-select and egress-supervision controller for the 1x3 router. Sits between the packet-control FSM, the three output FIFOs and the three egress ports.
- Latches the destination address during address decode. Steers the FSM's write enable and full status to the selected FIFO.
- Publishes per-port valid flags.
- Generates a one-cycle soft reset to any output FIFO whose data is not read within a timeout window.

Parameters:
- TIMEOUT, 30, consecutive unread-valid cycles before a soft reset fires on that channel; legal range 2..255.
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT-1.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- detect_add  in  1  FSM is in address-decode state.
- data_in  in  2  address field of incoming header (00/01/10 valid, 11 unused).
- write_enb_reg  in  1  FSM requests a FIFO write this cycle.
- read_enb  in  3  per-port read enable from egress, bit i = port i.
- empty  in  3  per-FIFO empty flags.
- full  in  3  per-FIFO full flags.
- write_enb  out  3  one-hot FIFO write enable.
- fifo_full  out  1  full flag of the selected FIFO, to FSM.
- vld_out  out  3  per-port data-valid.
- soft_reset  out  3  per-FIFO soft reset pulse, registered.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - addr_reg <= 2'b11 (no channel selected).
  - All timeout counters <= 0.
  - soft_reset <= 3'b000.
  - Combinational outputs then resolve to write_enb=000 and fifo_full=0; vld_out follows empty.
  - Reset asserted mid-packet is honoured on that edge and overrides all other updates.
- Address latch: at each clk edge with detect_add=1, addr_reg <= data_in, including 2'b11. addr_reg holds when detect_add=0.
- write_enb (combinational):
  - bit i = write_enb_reg AND (addr_reg == i).
  - addr_reg=11 gives 000. Never more than one bit set.
- fifo_full (combinational): full[addr_reg] for addr_reg in 0..2; 0 when addr_reg=11.
- vld_out[i] = ~empty[i] (combinational, zero latency).
- Timeout counter for each channel i, evaluated independently each edge:
  - If vld_out[i]=0 or read_enb[i]=1: cnt_i <= 0, soft_reset[i] <= 0.
  - Else if cnt_i == TIMEOUT-1: soft_reset[i] <= 1, cnt_i <= 0.
  - Else: cnt_i <= cnt_i+1, soft_reset[i] <= 0.
  - Net effect: soft_reset[i] is high for exactly one cycle, starting at the edge that completes TIMEOUT consecutive valid-and-unread cycles.
  - read_enb[i] sampled on the would-be firing edge wins: no pulse, counter clears.
  - If the FIFO is still non-empty after the pulse, counting restarts from 0. A second pulse needs another full TIMEOUT cycles.
  - Channels are fully independent; simultaneous pulses on several channels are legal.
- detect_add and a soft_reset pulse in the same cycle do not interact; addr_reg still updates.

Optional Feature:
- Macro ROUTER_CHAN_STATS_EN.
- When defined, adds output drop_cnt (24 bits): three 8-bit saturating counters, drop_cnt[8i+7:8i] for channel i.
  - Each counter increments on every cycle soft_reset[i]=1.
  - Saturates at 255 and clears only on resetn.
- When undefined, the port and counters are absent and all other behaviour is identical.

Test Plan:
- Reset, then detect_add=1, data_in=01, then write_enb_reg=1 -> write_enb=010. full=010 -> fifo_full=1; full=001 -> fifo_full=0.
- Latch data_in=11, write_enb_reg=1, full=111 -> write_enb=000, fifo_full=0.
- empty[2]=0, read_enb=0 held with TIMEOUT=30 -> soft_reset[2] rises at the 30th edge, high exactly 1 cycle. Held further -> next pulse 30 edges later.
- Same as above but read_enb[2]=1 on the 30th cycle -> no pulse; counter restarts, no pulse until 30 further unread cycles.
- empty=000, no reads, one port's read_enb pulsed at cycle 10 -> the other two pulse at the same edge, that port 10 cycles later.
- resetn=0 while cnt_0=20 and addr_reg=10 -> next cycle cnt_0=0, addr_reg=11, soft_reset=000. With ROUTER_CHAN_STATS_EN, 300 forced timeouts on channel 0 -> drop_cnt[7:0]=255.
